// File: rtl/l2_request_queue_pkg.sv
// Shared L2 request definitions: core count and the request payload carried from L1 to l2_cache.
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package l2_request_queue_pkg;

  localparam int unsigned L2RQ_NUM_CORES = `NUM_CORES;
  localparam int unsigned L2RQ_ADDR_W    = 32;
  localparam int unsigned L2RQ_TAG_W     = 6;

  typedef enum logic [1:0] {
    L2REQ_READ  = 2'd0,
    L2REQ_WRITE = 2'd1,
    L2REQ_EVICT = 2'd2,
    L2REQ_PREF  = 2'd3
  } l2req_op_e;

  typedef struct packed {
    logic [L2RQ_ADDR_W-1:0] addr;
    l2req_op_e              op;
    logic [L2RQ_TAG_W-1:0]  tag;
  } l2req_packet_t;

endpackage

// File: rtl/l2rq_core_fifo.sv
// Single-core request FIFO: unreset storage, wrapping pointers, count, and flags registered from next count.
module l2rq_core_fifo
  import l2_request_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push_valid,
  input  l2req_packet_t i_push_data,
  output logic          o_push_ready,
  output logic          o_pop_valid,
  output l2req_packet_t o_pop_data,
  input  logic          i_pop_ready,
  output logic          o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  l2req_packet_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ready;
  logic             r_valid;
  logic             r_full;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // Handshakes use only registered flags, so l2_ready never reaches core_ready.
  always_comb begin
    w_push      = i_push_valid & r_ready;
    w_pop       = r_valid & i_pop_ready;
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Flags are registered from the next count so they always match r_count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_ready <= (w_count_nxt < CNT_W'(DEPTH));
      r_valid <= (w_count_nxt != '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_push_ready = r_ready;
  assign o_pop_valid  = r_valid;
  assign o_pop_data   = r_mem[r_rd_ptr];
  assign o_full       = r_full;

endmodule

// File: rtl/l2_request_queue.sv
// Per-core request queues between the L1-side interfaces and l2_cache; one independent FIFO per core.
module l2_request_queue
  import l2_request_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic          [L2RQ_NUM_CORES-1:0]   core_request_valid,
  input  l2req_packet_t [L2RQ_NUM_CORES-1:0]   core_request,
  output logic          [L2RQ_NUM_CORES-1:0]   core_ready,
  output logic          [L2RQ_NUM_CORES-1:0]   l2i_request_valid,
  output l2req_packet_t [L2RQ_NUM_CORES-1:0]   l2i_request,
  input  logic          [L2RQ_NUM_CORES-1:0]   l2_ready,
  output logic          [L2RQ_NUM_CORES-1:0]   l2rq_perf_full
);

  for (genvar gi = 0; gi < int'(L2RQ_NUM_CORES); gi++) begin : g_core
    l2rq_core_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .i_push_valid (core_request_valid[gi]),
      .i_push_data  (core_request[gi]),
      .o_push_ready (core_ready[gi]),
      .o_pop_valid  (l2i_request_valid[gi]),
      .o_pop_data   (l2i_request[gi]),
      .i_pop_ready  (l2_ready[gi]),
      .o_full       (l2rq_perf_full[gi])
    );
  end

endmodule

// File: tb/tb_l2_request_queue.sv
// Bench for l2_request_queue: queue-per-core reference model checked every cycle, plus directed literal checks.
module tb_l2_request_queue;
  import l2_request_queue_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int          DEPTH_I = int'(DEPTH);
  localparam int          NC      = int'(L2RQ_NUM_CORES);

  logic                         clk;
  logic                         reset;
  logic          [NC-1:0]       core_request_valid;
  l2req_packet_t [NC-1:0]       core_request;
  logic          [NC-1:0]       core_ready;
  logic          [NC-1:0]       l2i_request_valid;
  l2req_packet_t [NC-1:0]       l2i_request;
  logic          [NC-1:0]       l2_ready;
  logic          [NC-1:0]       l2rq_perf_full;

  l2req_packet_t mq [NC][$];
  int n_cmp;
  int n_err;

  l2_request_queue #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .core_request_valid (core_request_valid),
    .core_request       (core_request),
    .core_ready         (core_ready),
    .l2i_request_valid  (l2i_request_valid),
    .l2i_request        (l2i_request),
    .l2_ready           (l2_ready),
    .l2rq_perf_full     (l2rq_perf_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic l2req_packet_t mk(input logic [31:0] a);
    l2req_packet_t p;
    p.addr = a;
    p.op   = l2req_op_e'($urandom_range(0, 3));
    p.tag  = L2RQ_TAG_W'($urandom);
    return p;
  endfunction

  // Model view: each core is a queue; ready = room left, valid = non-empty, head = oldest.
  task automatic check_all();
    for (int c = 0; c < NC; c++) begin
      int sz;
      sz = mq[c].size();
      chk($sformatf("core_ready[%0d]", c), 64'(core_ready[c]), 64'(sz < DEPTH_I));
      chk($sformatf("valid[%0d]", c), 64'(l2i_request_valid[c]), 64'(sz != 0));
      chk($sformatf("perf_full[%0d]", c), 64'(l2rq_perf_full[c]), 64'(sz == DEPTH_I));
      if (sz != 0) begin
        chk($sformatf("head[%0d]", c), 64'(l2i_request[c]), 64'(mq[c][0]));
      end
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < NC; c++) begin
      logic acc;
      logic deq;
      if (!reset) begin
        mq[c].delete();
      end else begin
        acc = core_request_valid[c] && (mq[c].size() < DEPTH_I);
        deq = (mq[c].size() != 0) && l2_ready[c];
        if (deq) void'(mq[c].pop_front());
        if (acc) mq[c].push_back(core_request[c]);
      end
    end
  endtask

  // One cycle: compare at the falling edge, then drive inputs for the next rising edge.
  task automatic step(input logic [NC-1:0] v, input l2req_packet_t [NC-1:0] d,
                      input logic [NC-1:0] r, output logic [NC-1:0] acc,
                      output logic [NC-1:0] pop);
    @(negedge clk);
    check_all();
    acc = core_ready & v;
    pop = l2i_request_valid & r;
    core_request_valid = v;
    core_request       = d;
    l2_ready           = r;
    model_update();
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic          [NC-1:0] v;
    logic          [NC-1:0] r;
    logic          [NC-1:0] acc;
    logic          [NC-1:0] pop;
    l2req_packet_t [NC-1:0] d;
    logic [31:0]            exp_addr [4];
    int                     nacc;
    int                     ndel;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    core_request_valid = '0;
    core_request = '0;
    l2_ready = '0;
    v = '0;
    r = '0;
    d = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset core_ready", 64'(core_ready), 64'({NC{1'b1}}));
    chk("reset valid", 64'(l2i_request_valid), 64'(0));
    chk("reset perf_full", 64'(l2rq_perf_full), 64'(0));
    reset = 1'b1;

    // Single request on core 0 appears one cycle after acceptance, then leaves.
    d = '0;
    d[0] = mk(32'h1000);
    step(NC'(1), d, {NC{1'b1}}, acc, pop);
    settle();
    chk("single acc", 64'(acc[0]), 64'(1));
    chk("single valid", 64'(l2i_request_valid[0]), 64'(1));
    chk("single addr", 64'(l2i_request[0].addr), 64'(32'h1000));
    step('0, d, {NC{1'b1}}, acc, pop);
    settle();
    chk("single drained", 64'(l2i_request_valid[0]), 64'(0));

    // Fill core 1 with six offers while l2 stalls it.
    nacc = 0;
    for (int k = 0; k < 6; k++) begin
      d = '0;
      d[1] = mk(32'h40 * 32'(k + 1));
      step(NC'(2), d, '0, acc, pop);
      nacc += int'(acc[1]);
    end
    settle();
    chk("fill accepted", 64'(nacc), 64'(4));
    chk("fill ready", 64'(core_ready[1]), 64'(0));
    chk("fill perf_full", 64'(l2rq_perf_full[1]), 64'(1));
    chk("fill head", 64'(l2i_request[1].addr), 64'(32'h40));

    // Full plus same-cycle dequeue: only the dequeue happens.
    d = '0;
    d[1] = mk(32'h200);
    step(NC'(2), d, NC'(2), acc, pop);
    settle();
    chk("full+deq acc", 64'(acc[1]), 64'(0));
    chk("full+deq ready", 64'(core_ready[1]), 64'(1));
    chk("full+deq perf_full", 64'(l2rq_perf_full[1]), 64'(0));
    chk("full+deq head", 64'(l2i_request[1].addr), 64'(32'h80));
    step(NC'(2), d, '0, acc, pop);
    settle();
    chk("retry acc", 64'(acc[1]), 64'(1));
    chk("retry perf_full", 64'(l2rq_perf_full[1]), 64'(1));

    exp_addr[0] = 32'h80;
    exp_addr[1] = 32'hC0;
    exp_addr[2] = 32'h100;
    exp_addr[3] = 32'h200;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain addr %0d", j), 64'(l2i_request[1].addr), 64'(exp_addr[j]));
      step('0, '0, NC'(2), acc, pop);
      settle();
    end
    chk("drain empty", 64'(l2i_request_valid[1]), 64'(0));

    // Core 0 held full while core 2 streams at full rate.
    for (int k = 0; k < 4; k++) begin
      d = '0;
      d[0] = mk(32'h2000 + 32'(k * 64));
      step(NC'(1), d, '0, acc, pop);
    end
    for (int k = 0; k < 8; k++) begin
      d = '0;
      d[0] = mk(32'hDEAD0);
      d[2] = mk(32'h3000 + 32'(k * 64));
      step(NC'(5), d, NC'(4), acc, pop);
      settle();
      chk($sformatf("indep acc %0d", k), 64'(acc[2]), 64'(1));
      chk($sformatf("indep ready %0d", k), 64'(core_ready[2]), 64'(1));
      chk($sformatf("indep valid %0d", k), 64'(l2i_request_valid[2]), 64'(1));
      chk($sformatf("indep core0 full %0d", k), 64'(l2rq_perf_full[0]), 64'(1));
    end
    repeat (6) step('0, '0, {NC{1'b1}}, acc, pop);

    // Twenty requests on core 3 against a 50% l2_ready.
    nacc = 0;
    ndel = 0;
    for (int k = 0; k < 400 && (nacc < 20 || ndel < 20); k++) begin
      d = '0;
      d[3] = mk(32'h7000 + 32'(nacc * 16));
      v = (nacc < 20) ? NC'(8) : '0;
      r = NC'(($urandom & 1) << 3);
      step(v, d, r, acc, pop);
      nacc += int'(acc[3]);
      ndel += int'(pop[3]);
    end
    chk("stream accepted", 64'(nacc), 64'(20));
    chk("stream delivered", 64'(ndel), 64'(20));

    // Asynchronous reset with three entries in core 0.
    for (int k = 0; k < 3; k++) begin
      d = '0;
      d[0] = mk(32'h4000 + 32'(k * 64));
      step(NC'(1), d, '0, acc, pop);
    end
    settle();
    chk("pre-reset valid", 64'(l2i_request_valid[0]), 64'(1));
    #1;
    reset = 1'b0;
    #1;
    chk("async reset valid", 64'(l2i_request_valid[0]), 64'(0));
    chk("async reset ready", 64'(core_ready[0]), 64'(1));
    for (int c = 0; c < NC; c++) mq[c].delete();
    repeat (2) step('0, '0, '0, acc, pop);
    settle();
    reset = 1'b1;
    repeat (3) step('0, '0, {NC{1'b1}}, acc, pop);
    d = '0;
    d[0] = mk(32'h5000);
    step(NC'(1), d, '0, acc, pop);
    settle();
    chk("post-reset head", 64'(l2i_request[0].addr), 64'(32'h5000));

    // Randomized traffic on all cores.
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < NC; c++) d[c] = mk($urandom);
      v = NC'($urandom);
      r = NC'($urandom);
      step(v, d, r, acc, pop);
    end
    repeat (DEPTH_I + 2) step('0, '0, {NC{1'b1}}, acc, pop);
    step('0, '0, '0, acc, pop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
